// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I fetch types and constants
// Contents: XLEN, NOP_INSTR (addi x0,x0,0), fetch_entry_t {pc, instr}.

package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_entry  write one entry at the tail
//   pop               drop the head entry
//   flush             empty the FIFO (wins over push/pop)
//   head              entry at rd_ptr (registered storage, no bypass)
//   count             number of valid entries

module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [IW-1:0] rd_ptr;
  logic [IW-1:0] wr_ptr;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  // Storage resets to {0, NOP} so the head shows a harmless NOP at PC 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !pop && (count == CW'(DEPTH))));
      // When full, wr_ptr == rd_ptr: a simultaneous push lands in the slot
      // being vacated by the pop, which becomes the new tail.
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction-fetch stage with prefetch FIFO
// Ports:
//   clk, rst_n                                  clock, async active-low reset
//   imem_req_valid/ready/addr                   word fetch requests
//   imem_rsp_valid/data                         in-order instruction returns
//   redirect_valid/pc                           EX branch/jump redirect (flush)
//   out_valid/ready, out_pc, out_instr          handoff to decode

module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] pcq [DEPTH];
  logic [IW-1:0]   pcq_rd;
  logic [IW-1:0]   pcq_wr;

  logic            req_fire;
  logic            fifo_push;
  logic            fifo_pop;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  // Credits: buffered plus in-flight (including to-be-dropped) never exceed
  // DEPTH, so every response always has a FIFO slot.
  assign imem_req_valid = rst_n & ((SW'(fifo_count) + SW'(outstanding)) < SW'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign out_valid  = (fifo_count != '0) & ~redirect_valid;
  assign fifo_pop   = out_valid & out_ready;
  assign fifo_push  = imem_rsp_valid & ~redirect_valid & (drop == '0);
  assign push_entry = '{pc: pcq[pcq_rd], instr: imem_rsp_data};

  assign out_pc    = fifo_head.pc;
  assign out_instr = fifo_head.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      // The PC queue is not flushed on redirect: dropped responses still
      // retire their entries so it stays aligned with the imem order.
      if (req_fire)       pcq_wr <= next_ptr(pcq_wr);
      if (imem_rsp_valid) pcq_rd <= next_ptr(pcq_rd);
      if (redirect_valid) begin
        pc   <= redirect_pc & ~XLEN'(3);
        drop <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      end else begin
        if (req_fire)                       pc   <= pc + XLEN'(4);
        if (imem_rsp_valid && drop != '0)   drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_wr] <= pc;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head       (fifo_head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a queue-based reference model

module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  logic        w_req_valid, w_req_ready, w_rsp_valid, w_out_valid, w_out_ready;
  logic [31:0] w_req_addr, w_rsp_data, w_redirect_pc, w_out_pc, w_out_instr;
  logic        w_redirect_valid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  typedef struct {
    logic [31:0] pc;
    bit          wrong;
  } infl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  infl_t       infl[$];
  ent_t        fifo_q[$];
  logic [31:0] m_pc;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] wrap_exp [3];
  int          w_idx;
  bit          w_fire_prev;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_8133;
      32'h8:   return 32'h0011_02B3;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    fifo_q.delete();
    m_pc        = 32'h0;
    w_idx       = 0;
    w_fire_prev = 1'b0;
  endtask

  task automatic cycle(input bit rst, input bit rdy, input int rsp_pct,
                       input bit redir, input logic [31:0] rpc, input bit ordy);
    bit    fire, rsp, pop, exp_rv, exp_ov;
    infl_t e;
    @(negedge clk);
    rst_n = rst;
    if (!rst) model_reset();
    imem_req_ready = rdy;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp = rst && (infl.size() > 0) && ($urandom_range(99) < rsp_pct);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(infl[0].pc) : $urandom;
    w_rsp_valid    = rst & w_fire_prev;
    #1;
    if (!rst) begin
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr", out_instr, NOP_INSTR);
      @(posedge clk);
      return;
    end
    exp_rv = (fifo_q.size() + infl.size()) < DEPTH;
    exp_ov = (fifo_q.size() > 0) && !redir;
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_pc", out_pc, fifo_q[0].pc);
      check("out_instr", out_instr, fifo_q[0].instr);
    end
    if (w_req_valid && w_idx < 3) begin
      check("wrap_addr", w_req_addr, wrap_exp[w_idx]);
      w_idx++;
    end
    w_fire_prev = w_req_valid;

    fire = exp_rv && rdy;
    pop  = exp_ov && ordy;
    if (rsp) e = infl.pop_front();
    if (redir) begin
      fifo_q.delete();
      foreach (infl[i]) infl[i].wrong = 1'b1;
      if (fire) infl.push_back('{pc: m_pc, wrong: 1'b1});
      m_pc = rpc & ~32'h3;
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (rsp && !e.wrong) fifo_q.push_back('{pc: e.pc, instr: mem_word(e.pc)});
      if (fire) begin
        infl.push_back('{pc: m_pc, wrong: 1'b0});
        m_pc = m_pc + 32'h4;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = NOP_INSTR;
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_out_ready = 1'b1;
    model_reset();

    repeat (3) cycle(1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    // streaming with a 1-cycle imem
    repeat (10) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    // stall mid-stream, then resume
    repeat (5) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b0);
    repeat (6) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    // build two in flight, then redirect to 0x100
    repeat (4) cycle(1'b1, 1'b1, 0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 0, 1'b1, 32'h100, 1'b1);
    repeat (8) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    // misaligned target is forced to a word boundary
    repeat (3) cycle(1'b1, 1'b1, 0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 100, 1'b1, 32'h102, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    // redirect + response + request fire in one cycle
    repeat (4) cycle(1'b1, 1'b0, 100, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 100, 1'b1, 32'h200, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    // back-to-back redirects: last wins
    cycle(1'b1, 1'b1, 100, 1'b1, 32'h300, 1'b1);
    cycle(1'b1, 1'b1, 100, 1'b1, 32'h400, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    // asynchronous reset between edges
    repeat (3) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_req_valid", 32'(imem_req_valid), 32'h0);
    check("async_wrap_req_valid", 32'(w_req_valid), 32'h0);
    model_reset();
    repeat (2) cycle(1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    repeat (8) cycle(1'b1, 1'b1, 100, 1'b0, 32'h0, 1'b1);
    // randomized traffic
    repeat (600) cycle(1'b1, 1'($urandom_range(1)), int'($urandom_range(100)),
                       ($urandom_range(15) == 0), $urandom, ($urandom_range(3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
